des_seq: RTL and testbench
==========================

DES_SEQ -- requirements
Module: des_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 in_valid  input  1  request present; in_key and in_decrypt are valid.
REQ-004 in_ready  output  1  sequencer can accept a request.
REQ-005 in_key  input  64  DES key, bit numbering [64:1], parity bits ignored.
REQ-006 in_decrypt  input  1  0 = encrypt subkey order K1..K16, 1 = decrypt order K16..K1.
REQ-007 dp_load  output  1  one-cycle pulse: round datapath loads IP(message).
REQ-008 dp_round_en  output  1  round datapath performs one Feistel round this cycle.
REQ-009 dp_subkey  output  48  subkey for the current round, bit numbering [48:1].
REQ-010 dp_final  output  1  one-cycle pulse: datapath applies swap + FP into its output register.
REQ-011 round_cnt  output  5  current round number 1..16, 0 outside ROUND.
REQ-012 out_valid  output  1  datapath result ready for consumer.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, LOAD, ROUND, FINAL, DONE; one-hot or binary encoding, sequencer's choice.
REQ-016 IDLE: in_ready=1; in_valid=1 -> capture PC-1(in_key) into C/D (28+28 bits) and in_decrypt, go LOAD.
REQ-017 LOAD: dp_load=1 for exactly one cycle; compute round-1 C/D; go ROUND with round_cnt=1.
REQ-018 ROUND: dp_round_en=1 every cycle; dp_subkey=PC-2(C,D) for current round; round_cnt increments 1..16; after round 16 go FINAL.
REQ-019 Encrypt schedule: before round i, C and D rotate left by s(i), s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 Decrypt schedule: round 1 uses PC-2 of unrotated C0/D0; before round i>1, C and D rotate right by s(18-i).
REQ-021 FINAL: dp_final=1 for one cycle; go DONE.
REQ-022 DONE: out_valid=1 held until out_ready=1; on out_valid & out_ready go IDLE next cycle.
REQ-023 Latency: accept at cycle 0 -> dp_load cycle 1 -> rounds cycles 2..17 -> dp_final cycle 18 -> out_valid from cycle 19.
REQ-024 out_ready high before DONE has no effect; in_valid outside IDLE ignored, in_ready=0.
REQ-025 in_key/in_decrypt changes after acceptance have no effect on the running job.
REQ-026 dp_subkey=0 in every state except ROUND.
REQ-027 Back-to-back: completing handshake in DONE then in_valid in IDLE next cycle -> minimum request spacing 20 cycles.

Reset
REQ-028 rst_n low asynchronously forces IDLE, C/D=0, round_cnt=0, dp_*=0, out_valid=0, busy=0, in_ready=1 (after release).
REQ-029 Reset asserted mid-job (any state) abandons the job; no dp_final or out_valid produced for it.

Configuration
REQ-030 Macro DES_SEQ_ABORT_EN defined: extra input abort (1 bit); abort=1 in LOAD, ROUND or FINAL forces IDLE next cycle, no dp_final/out_valid; abort ignored in IDLE and DONE.
REQ-031 Macro DES_SEQ_ABORT_EN undefined: no abort port; FSM always runs to DONE.

Verification
REQ-032 Encrypt, in_key=0x133457799BBCDFF1 -> round 1 dp_subkey=0x1B02EFFC7072, round 16 dp_subkey=0xCB3D8B0E17F5, dp_final cycle 18, out_valid cycle 19.
REQ-033 Same key, in_decrypt=1 -> round 1 dp_subkey=0xCB3D8B0E17F5, round 16 dp_subkey=0x1B02EFFC7072.
REQ-034 With round datapath, key 0x133457799BBCDFF1, message 0x0123456789ABCDEF -> cipher 0x85E813540F0AB405; decrypt of it -> 0x0123456789ABCDEF.
REQ-035 out_ready held low 10 cycles in DONE -> out_valid stays 1, in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low during round 8 -> all outputs 0 immediately, no out_valid afterwards; new request then completes normally.
REQ-037 DES_SEQ_ABORT_EN defined, abort=1 during round 5 -> IDLE next cycle, in_ready=1, no dp_final.

Source files
------------

// File: rtl/des_seq_if.sv
// DES key-schedule sequencer bus.
// Groups the request handshake, the round-datapath control outputs and the
// result handshake. Signal names match the sequencer's external contract.
// The master side drives requests and accepts results; the slave side is
// the sequencer itself.
interface des_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        dp_load;
  logic        dp_round_en;
  logic [47:0] dp_subkey;
  logic        dp_final;
  logic [4:0]  round_cnt;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output in_valid, in_key, in_decrypt, out_ready,
    input  in_ready, dp_load, dp_round_en, dp_subkey, dp_final,
           round_cnt, out_valid, busy
  );

  modport slave (
    input  in_valid, in_key, in_decrypt, out_ready,
    output in_ready, dp_load, dp_round_en, dp_subkey, dp_final,
           round_cnt, out_valid, busy
  );
endinterface

// File: rtl/des_seq.sv
// DES key-schedule sequencer.
// Accepts a 64-bit key, produces the 16 round subkeys (encrypt order
// K1..K16 or decrypt order K16..K1) one per cycle, and drives the load /
// round / final strobes of an external Feistel round datapath.
// Timeline: accept (cycle 0), dp_load (1), rounds (2..17), dp_final (18),
// out_valid from cycle 19 until out_ready.
// Optional feature: define DES_SEQ_ABORT_EN to add an 'abort' input that
// cancels a job in LOAD, ROUND or FINAL.
// Key bits use DES numbering: DES bit n of the key is in_key[64-n].
module des_seq (
  input logic        clk,
  input logic        rst_n,
`ifdef DES_SEQ_ABORT_EN
  input logic        abort,
`endif
  des_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Permuted choice 1: 64-bit key -> C0 (upper 28) / D0 (lower 28).
  // Parity bits 8,16,...,64 are never selected.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    return {
      // C half
      k[64-57], k[64-49], k[64-41], k[64-33], k[64-25], k[64-17], k[64-9],
      k[64-1],  k[64-58], k[64-50], k[64-42], k[64-34], k[64-26], k[64-18],
      k[64-10], k[64-2],  k[64-59], k[64-51], k[64-43], k[64-35], k[64-27],
      k[64-19], k[64-11], k[64-3],  k[64-60], k[64-52], k[64-44], k[64-36],
      // D half
      k[64-63], k[64-55], k[64-47], k[64-39], k[64-31], k[64-23], k[64-15],
      k[64-7],  k[64-62], k[64-54], k[64-46], k[64-38], k[64-30], k[64-22],
      k[64-14], k[64-6],  k[64-61], k[64-53], k[64-45], k[64-37], k[64-29],
      k[64-21], k[64-13], k[64-5],  k[64-28], k[64-20], k[64-12], k[64-4]
    };
  endfunction

  // Permuted choice 2: 56-bit C||D -> 48-bit subkey, DES bit n of C||D
  // lives at cd[56-n].
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    return {
      cd[56-14], cd[56-17], cd[56-11], cd[56-24], cd[56-1],  cd[56-5],
      cd[56-3],  cd[56-28], cd[56-15], cd[56-6],  cd[56-21], cd[56-10],
      cd[56-23], cd[56-19], cd[56-12], cd[56-4],  cd[56-26], cd[56-8],
      cd[56-16], cd[56-7],  cd[56-27], cd[56-20], cd[56-13], cd[56-2],
      cd[56-41], cd[56-52], cd[56-31], cd[56-37], cd[56-47], cd[56-55],
      cd[56-30], cd[56-40], cd[56-51], cd[56-45], cd[56-33], cd[56-48],
      cd[56-44], cd[56-49], cd[56-39], cd[56-56], cd[56-34], cd[56-53],
      cd[56-46], cd[56-42], cd[56-50], cd[56-36], cd[56-29], cd[56-32]
    };
  endfunction

  // Standard DES shift schedule s(i): one position for rounds 1,2,9,16,
  // two otherwise.
  function automatic logic [1:0] sched_shift(input logic [4:0] i);
    return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  // Rotation applied to C/D on the way into round n.
  // Encrypt rotates left by s(n). Decrypt starts from the unrotated C0/D0
  // (which equal C16/D16, total left shift is 28) and walks backwards by
  // rotating right by s(18-n).
  function automatic logic [1:0] shift_amt(input logic [4:0] n, input logic dec);
    logic [1:0] amt;
    if (!dec)
      amt = sched_shift(n);
    else if (n == 5'd1)
      amt = 2'd0;
    else
      amt = sched_shift(5'd18 - n);
    return amt;
  endfunction

  // 28-bit rotate by 0..2 places, right when decrypting, left otherwise.
  function automatic logic [27:0] rot28(input logic [27:0] c,
                                        input logic [1:0]  amt,
                                        input logic        dec);
    logic [27:0] r;
    case (amt)
      2'd1:    r = dec ? {c[0], c[27:1]}   : {c[26:0], c[27]};
      2'd2:    r = dec ? {c[1:0], c[27:2]} : {c[25:0], c[27:26]};
      default: r = c;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_dec;
  logic [4:0]  r_round;
  logic [47:0] r_subkey;
  logic        r_load;
  logic        r_round_en;
  logic        r_final;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_in_ready;

  logic [55:0] w_cd0;
  logic [4:0]  w_next_round;
  logic [1:0]  w_shift;
  logic [27:0] w_c_nxt;
  logic [27:0] w_d_nxt;
  logic [47:0] w_subkey_nxt;

  // Key halves and subkey for the round about to start (round 1 from LOAD,
  // round_cnt+1 from ROUND).
  always_comb begin
    w_cd0        = pc1(bus.in_key);
    w_next_round = (r_state == S_ROUND) ? (r_round + 5'd1) : 5'd1;
    w_shift      = shift_amt(w_next_round, r_dec);
    w_c_nxt      = rot28(r_c, w_shift, r_dec);
    w_d_nxt      = rot28(r_d, w_shift, r_dec);
    w_subkey_nxt = pc2({w_c_nxt, w_d_nxt});
  end

  // Sequencer FSM; every output is a register updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_d         <= '0;
      r_dec       <= 1'b0;
      r_round     <= '0;
      r_subkey    <= '0;
      r_load      <= 1'b0;
      r_round_en  <= 1'b0;
      r_final     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_load  <= 1'b0;
      r_final <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_c        <= w_cd0[55:28];
            r_d        <= w_cd0[27:0];
            r_dec      <= bus.in_decrypt;
            r_load     <= 1'b1;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_c        <= w_c_nxt;
          r_d        <= w_d_nxt;
          r_subkey   <= w_subkey_nxt;
          r_round    <= 5'd1;
          r_round_en <= 1'b1;
          r_state    <= S_ROUND;
        end
        S_ROUND: begin
          if (r_round == 5'd16) begin
            r_round    <= '0;
            r_round_en <= 1'b0;
            r_subkey   <= '0;
            r_final    <= 1'b1;
            r_state    <= S_FINAL;
          end else begin
            r_c      <= w_c_nxt;
            r_d      <= w_d_nxt;
            r_subkey <= w_subkey_nxt;
            r_round  <= w_next_round;
          end
        end
        S_FINAL: begin
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_round     <= '0;
          r_round_en  <= 1'b0;
          r_subkey    <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
`ifdef DES_SEQ_ABORT_EN
      // Abort drops the job before any dp_final / out_valid is produced.
      if (abort && (r_state == S_LOAD || r_state == S_ROUND || r_state == S_FINAL)) begin
        r_load      <= 1'b0;
        r_round_en  <= 1'b0;
        r_final     <= 1'b0;
        r_round     <= '0;
        r_subkey    <= '0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
        r_in_ready  <= 1'b1;
        r_state     <= S_IDLE;
      end
`endif
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.dp_load     = r_load;
  assign bus.dp_round_en = r_round_en;
  assign bus.dp_subkey   = r_subkey;
  assign bus.dp_final    = r_final;
  assign bus.round_cnt   = r_round;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_des_seq.sv
// Testbench for des_seq: known-answer table, random keys against a
// key-schedule reference model, and hand-written reset / stall / abort
// sequences.
module tb_des_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef DES_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  des_seq_if bus();

  des_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DES_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {dp_load, dp_round_en, dp_final, out_valid, busy, in_ready}
  localparam logic [5:0] C_IDLE  = 6'b000001;
  localparam logic [5:0] C_LOAD  = 6'b100010;
  localparam logic [5:0] C_ROUND = 6'b010010;
  localparam logic [5:0] C_FINAL = 6'b001010;
  localparam logic [5:0] C_DONE  = 6'b000110;

  int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                   10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                   23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                   41,52,31,37,47,55,30,40,51,45,33,48,
                   44,49,39,56,34,53,46,42,50,36,29,32};
  int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] m_ks [16];   // expected subkey for round index 0..15
  logic [47:0] got_k1;
  logic [47:0] got_k16;

  function automatic logic [5:0] ctl();
    return {bus.dp_load, bus.dp_round_en, bus.dp_final, bus.out_valid, bus.busy, bus.in_ready};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference key schedule: Ki = PC2(C0 <<< t_i || D0 <<< t_i), where t_i
  // is the cumulative shift count up to round i; decrypt reverses the list.
  task automatic model_schedule(input logic [63:0] key, input logic dec);
    logic [55:0] cd0;
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    logic [47:0] k;
    logic [47:0] enc [16];
    int t;
    cd0 = '0;
    for (int j = 0; j < 56; j++) cd0 = {cd0[54:0], key[6'(64 - PC1[j])]};
    c0 = cd0[55:28];
    d0 = cd0[27:0];
    t = 0;
    for (int i = 0; i < 16; i++) begin
      t += SH[i];
      c = 28'((c0 << t) | (c0 >> (28 - t)));
      d = 28'((d0 << t) | (d0 >> (28 - t)));
      cd = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) k = {k[46:0], cd[6'(56 - PC2[j])]};
      enc[i] = k;
    end
    for (int i = 0; i < 16; i++) m_ks[i] = dec ? enc[15 - i] : enc[i];
  endtask

  // One full job. Called at #1 after a posedge with the DUT in IDLE.
  // in_valid stays high with junk and out_ready is pulsed early to show
  // both are ignored while busy; 'hold' cycles of out_ready=0 in DONE.
  task automatic run_job(input logic [63:0] key, input logic dec, input int hold);
    model_schedule(key, dec);
    chk("idle_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});
    bus.in_valid   = 1'b1;
    bus.in_key     = key;
    bus.in_decrypt = dec;
    @(posedge clk); #1;
    bus.in_key     = {$urandom, $urandom};
    bus.in_decrypt = ~dec;
    bus.out_ready  = 1'b1;
    chk("load_ctl", {58'd0, ctl()}, {58'd0, C_LOAD});
    chk("load_subkey", {16'd0, bus.dp_subkey}, 64'd0);
    for (int r = 1; r <= 16; r++) begin
      @(posedge clk); #1;
      chk($sformatf("round%0d_ctl", r), {58'd0, ctl()}, {58'd0, C_ROUND});
      chk($sformatf("round%0d_cnt", r), {59'd0, bus.round_cnt}, 64'(r));
      chk($sformatf("round%0d_subkey", r), {16'd0, bus.dp_subkey}, {16'd0, m_ks[r - 1]});
      if (r == 1)  got_k1  = bus.dp_subkey;
      if (r == 16) got_k16 = bus.dp_subkey;
    end
    @(posedge clk); #1;
    chk("final_ctl", {58'd0, ctl()}, {58'd0, C_FINAL});
    chk("final_cnt_subkey", {11'd0, bus.round_cnt, bus.dp_subkey}, 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("done_stall_ctl", {58'd0, ctl()}, {58'd0, C_DONE});
      @(posedge clk); #1;
    end
    chk("done_ctl", {58'd0, ctl()}, {58'd0, C_DONE});
    chk("done_cnt_subkey", {11'd0, bus.round_cnt, bus.dp_subkey}, 64'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("after_handshake_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] k1;
    logic [47:0] k16;
    int          hold;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    logic seen;
    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 10};
    vecs[2] = '{64'h0000000000000000, 1'b0, 48'h000000000000, 48'h000000000000, 1};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 0};
    vecs[4] = '{64'h0101010101010101, 1'b0, 48'h000000000000, 48'h000000000000, 2};
    vecs[5] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 0};
    vecs[6] = '{64'h133457799BBCDFF0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0};
    vecs[7] = '{64'h123456789ABCDEF0, 1'b1, 48'h0, 48'h0, 3}; // k1/k16 from model

    bus.in_valid   = 1'b0;
    bus.in_key     = '0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state while held and after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});
    chk("reset_held_cnt_subkey", {11'd0, bus.round_cnt, bus.dp_subkey}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});

    // Known-answer table
    for (int v = 0; v < 8; v++) begin
      run_job(vecs[v].key, vecs[v].dec, vecs[v].hold);
      if (v == 7) begin
        vecs[v].k1  = m_ks[0];
        vecs[v].k16 = m_ks[15];
      end
      chk($sformatf("vec%0d_k1", v),  {16'd0, got_k1},  {16'd0, vecs[v].k1});
      chk($sformatf("vec%0d_k16", v), {16'd0, got_k16}, {16'd0, vecs[v].k16});
    end

    // Randomized keys, direction and stall length; jobs run back-to-back
    for (int n = 0; n < 10; n++) begin
      run_job({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset pulsed during round 8, then a fresh job
    bus.in_valid = 1'b1;
    bus.in_key   = 64'h133457799BBCDFF1;
    bus.in_decrypt = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_round", {59'd0, bus.round_cnt}, 64'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});
    chk("async_reset_cnt_subkey", {11'd0, bus.round_cnt, bus.dp_subkey}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.dp_final || bus.busy) seen = 1'b1;
    end
    chk("abandoned_job_silent", {63'd0, seen}, 64'd0);
    run_job(64'h133457799BBCDFF1, 1'b0, 0);
    chk("post_reset_k16", {16'd0, got_k16}, {16'd0, 48'hCB3D8B0E17F5});

`ifdef DES_SEQ_ABORT_EN
    // Abort during round 5
    bus.in_valid = 1'b1;
    bus.in_key   = 64'h133457799BBCDFF1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_round", {59'd0, bus.round_cnt}, 64'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ctl", {58'd0, ctl()}, {58'd0, C_IDLE});
    chk("abort_cnt_subkey", {11'd0, bus.round_cnt, bus.dp_subkey}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.dp_final) seen = 1'b1;
    end
    chk("aborted_job_silent", {63'd0, seen}, 64'd0);
    run_job(64'h0E329232EA6D0D73, 1'b1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
